if_fetch_pipe: RTL and testbench

- Parametrised successor to the single-cycle fetch stage. Holds the PC and issues in-order requests to a variable-latency instruction memory over a valid/ready request channel.
- Buffers returned instructions with their PCs in a FQ_DEPTH-entry fetch buffer and presents them to decode over a valid/ready handshake.
- Next-PC selection is no longer local: sequential PC+4 by default, overridden by a single redirect port from execute (branch/jump/trap), with flush and stale-response discard.

---
 rtl/if_pkg.sv | 16 +
 rtl/if_fetch_buf.sv | 74 +++++++
 rtl/if_fetch_pipe.sv | 87 ++++++++
 tb/tb_if_fetch_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared widths, fetch-entry type and pointer sizing for the fetch pipe
package if_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            filled;
        logic            misalign;
    } fetch_entry_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: in-order ring of fetch entries, allocated at request, filled at response
module if_fetch_buf
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_inst,
    input  logic            pop,
    input  logic            flush,
    input  logic            ins,
    input  fetch_entry_t    ins_entry,
    output fetch_entry_t    head,
    output logic [PW-1:0]   count,
    output logic [PW-1:0]   inflight
);
    localparam int IW = PW - 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;

    // Flush clears every filled bit so a recycled slot never looks valid
    always_comb begin
        mem_d   = mem_q;
        alloc_d = alloc_q;
        fill_d  = fill_q;
        head_d  = head_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i].filled = 1'b0;
            if (ins) mem_d[alloc_q[IW-1:0]] = ins_entry;
            head_d  = alloc_q;
            alloc_d = alloc_q + PW'(ins);
            fill_d  = alloc_d;
        end else begin
            if (alloc) begin
                mem_d[alloc_q[IW-1:0]] = '{pc: alloc_pc, inst: '0, filled: 1'b0, misalign: 1'b0};
                alloc_d = alloc_q + PW'(1);
            end
            if (fill) begin
                mem_d[fill_q[IW-1:0]].inst   = fill_inst;
                mem_d[fill_q[IW-1:0]].filled = 1'b1;
                fill_d = fill_q + PW'(1);
            end
            if (pop) begin
                mem_d[head_q[IW-1:0]].filled = 1'b0;
                head_d = head_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            alloc_q <= '0;
            fill_q  <= '0;
            head_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            head_q  <= head_d;
        end
    end

    assign head     = mem_q[head_q[IW-1:0]];
    assign count    = alloc_q - head_q;
    assign inflight = alloc_q - fill_q;
endmodule

// File: rtl/if_fetch_pipe.sv
// if_fetch_pipe: PC, request issue, redirect flush and stale-response drop around a fetch buffer
// Define IF_MISALIGN_TRAP_EN to turn misaligned redirects into a single marked NOP entry.
module if_fetch_pipe
    import if_pkg::*;
#(
    parameter int              XLEN     = if_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4,
    output logic [XLEN-1:0] out_inst,
    output logic            out_misalign
);
    localparam int PW = ptr_w(FQ_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   drop_q, drop_d, count, inflight;
    logic            halt_q, halt_d, req_fire, fill, pop, ins;
    fetch_entry_t    head, ins_entry;

`ifdef IF_MISALIGN_TRAP_EN
    assign ins = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign ins = 1'b0;
`endif
    assign ins_entry = '{pc: redirect_pc, inst: INST_NOP, filled: 1'b1, misalign: 1'b1};

    assign imem_req_valid = !rst && !redirect_valid && !halt_q && drop_q == '0 && count < PW'(FQ_DEPTH);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign fill           = imem_rsp_valid && drop_q == '0 && !redirect_valid;
    assign pop            = out_valid && out_ready && !redirect_valid;

    // A response arriving in the redirect cycle is already counted out of inflight
    always_comb begin
        pc_d   = redirect_valid ? (redirect_pc & ~XLEN'(3)) : req_fire ? pc_q + XLEN'(4) : pc_q;
        drop_d = redirect_valid ? drop_q + inflight - PW'(imem_rsp_valid)
               : (imem_rsp_valid && drop_q != '0) ? drop_q - PW'(1) : drop_q;
        halt_d = redirect_valid ? ins : halt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
            halt_q <= halt_d;
        end
    end

    if_fetch_buf #(.DEPTH(FQ_DEPTH), .PW(PW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .alloc     (req_fire),
        .alloc_pc  (pc_q),
        .fill      (fill),
        .fill_inst (imem_rsp_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .ins       (ins),
        .ins_entry (ins_entry),
        .head      (head),
        .count     (count),
        .inflight  (inflight)
    );

    assign out_valid    = head.filled;
    assign out_pc       = out_valid ? head.pc : '0;
    assign out_pc4      = out_valid ? head.pc + XLEN'(4) : '0;
    assign out_inst     = out_valid ? head.inst : '0;
    assign out_misalign = out_valid && head.misalign;
endmodule

// File: tb/tb_if_fetch_pipe.sv
// tb_if_fetch_pipe: directed checks of issue, buffering, redirect, drop and reset with a latency-modelled memory
module tb_if_fetch_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc, out_pc4, out_inst;
    logic        out_misalign;

    always #5 clk = ~clk;

    if_fetch_pipe #(.XLEN(32), .RESET_PC(32'h100), .FQ_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc4(out_pc4),
        .out_inst(out_inst), .out_misalign(out_misalign)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] req_log[$], opc_log[$], opc4_log[$], oinst_log[$];
    int          cyc = 0, lat = 1, nvec = 0, nmis = 0;
    logic        found;

    function automatic logic [31:0] mf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        opc_log.delete();
        opc4_log.delete();
        oinst_log.delete();
    endtask

    task automatic tick();
        logic rf, of;
        logic [31:0] ra, op, op4, oi;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mf(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        rf  = imem_req_valid && imem_req_ready;
        ra  = imem_req_addr;
        of  = out_valid && out_ready && !redirect_valid;
        op  = out_pc;
        op4 = out_pc4;
        oi  = out_inst;
        @(posedge clk);
        #1;
        if (rst) begin
            pend.delete();
        end else begin
            if (imem_rsp_valid) void'(pend.pop_front());
            if (rf) begin
                pend.push_back('{addr: ra, due: cyc + lat});
                req_log.push_back(ra);
            end
            if (of) begin
                opc_log.push_back(op);
                opc4_log.push_back(op4);
                oinst_log.push_back(oi);
            end
        end
        cyc++;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_pc4", out_pc4, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_mis", out_misalign, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", imem_req_valid, 1);
        chk("post_rst_addr", imem_req_addr, 32'h100);

        clear_logs();
        for (int i = 0; i < 10; i++) tick();
        chk("seq_req0", at(req_log, 0), 32'h100);
        chk("seq_req1", at(req_log, 1), 32'h104);
        chk("seq_req2", at(req_log, 2), 32'h108);
        chk("seq_pc0", at(opc_log, 0), 32'h100);
        chk("seq_pc1", at(opc_log, 1), 32'h104);
        chk("seq_pc2", at(opc_log, 2), 32'h108);
        chk("seq_pc4_0", at(opc4_log, 0), 32'h104);
        chk("seq_pc4_2", at(opc4_log, 2), 32'h10C);
        chk("seq_inst0", at(oinst_log, 0), mf(32'h100));
        chk("seq_inst2", at(oinst_log, 2), mf(32'h108));

        clear_logs();
        out_ready = 1'b0;
        redirect_to(32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_nreq", req_log.size(), 2);
        chk("stall_req0", at(req_log, 0), 32'h0);
        chk("stall_req1", at(req_log, 1), 32'h4);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("resume_req2", at(req_log, 2), 32'h8);
        chk("resume_pc0", at(opc_log, 0), 32'h0);
        chk("resume_pc1", at(opc_log, 1), 32'h4);
        chk("resume_pc2", at(opc_log, 2), 32'h8);

        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pend.size() == 2) found = 1'b1;
        end
        chk("lat3_inflight2", found, 1);
        clear_logs();
        redirect_to(32'h200);
        chk("drop_req_hold", imem_req_valid, 0);
        for (int i = 0; i < 15; i++) tick();
        chk("redir_req0", at(req_log, 0), 32'h200);
        chk("redir_pc0", at(opc_log, 0), 32'h200);
        chk("redir_inst0", at(oinst_log, 0), mf(32'h200));
        lat = 1;

        imem_req_ready = 1'b0;
        redirect_to(32'h500);
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", imem_req_valid, 1);
            chk("hold_addr", imem_req_addr, 32'h500);
            tick();
        end
        clear_logs();
        imem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("hold_req0", at(req_log, 0), 32'h500);
        chk("hold_req1", at(req_log, 1), 32'h504);

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("full_out_valid", out_valid, 1);
        chk("full_req_valid", imem_req_valid, 0);
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_req_valid", imem_req_valid, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_addr", imem_req_addr, 32'h100);
        clear_logs();
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_req0", at(req_log, 0), 32'h100);

`ifdef IF_MISALIGN_TRAP_EN
        out_ready = 1'b0;
        clear_logs();
        redirect_to(32'h302);
        chk("mis_valid", out_valid, 1);
        chk("mis_pc", out_pc, 32'h302);
        chk("mis_flag", out_misalign, 1);
        chk("mis_inst", out_inst, 32'h13);
        chk("mis_req_valid", imem_req_valid, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("mis_nreq", req_log.size(), 0);
        out_ready = 1'b1;
        tick();
        chk("mis_pop_pc", at(opc_log, 0), 32'h302);
        chk("mis_after_pop", out_valid, 0);
        clear_logs();
        redirect_to(32'h400);
        for (int i = 0; i < 10; i++) tick();
        chk("mis_resume_req", at(req_log, 0), 32'h400);
        chk("mis_resume_pc", at(opc_log, 0), 32'h400);
`else
        clear_logs();
        redirect_to(32'h302);
        chk("align_mis", out_misalign, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("align_req0", at(req_log, 0), 32'h300);
        chk("align_pc0", at(opc_log, 0), 32'h300);
        chk("align_inst0", at(oinst_log, 0), mf(32'h300));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
